mod_counter: RTL

Parametrised modulo-N up/down counter: the general-purpose successor to the fixed 4-bit, modulo-16 up/down counter. It adds configurable width and modulus, count enable, synchronous clear and load, and a wrap-or-saturate mode. It also provides a terminal-count output so stages can be cascaded into multi-digit counters, such as BCD time-of-day or event counters. It sits between control logic and display/compare logic and is used standalone or chained.

---
 rtl/cnt_pkg.sv | 26 ++
 rtl/mod_counter.sv | 118 +++++++++++
 2 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo-N counter family: direction encoding and
// a width helper for integrators sizing WIDTH from MODULUS.
package cnt_pkg;

    localparam logic CNT_DIR_UP   = 1'b0;
    localparam logic CNT_DIR_DOWN = 1'b1;

    // Smallest number of bits able to index v distinct values (minimum 1).
    function automatic int clog2(input longint unsigned v);
        longint unsigned acc;
        int bits;
        acc  = 64'd1;
        bits = 0;
        while (acc < v) begin
            acc  = acc << 1;
            bits = bits + 1;
        end
        if (bits == 0) begin
            bits = 1;
        end else begin
            bits = bits;
        end
        return bits;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with clear, load, wrap-or-saturate
// behaviour and a combinational terminal count for cascading stages.
module mod_counter
    import cnt_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_sat
);

    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
        $fatal(1, "mod_counter: WIDTH must be in 2..32");
    end
    if ((MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_modulus
        $fatal(1, "mod_counter: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH:0]   MOD_W   = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   ONE_W   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   LIMIT_W = MOD_W - ONE_W;
    localparam logic [WIDTH-1:0] LIMIT   = LIMIT_W[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic [WIDTH:0]   cnt_ext_s, sum_s, diff_s, load_ext_s;
    logic             at_top_s, at_bot_s;
    logic [WIDTH-1:0] load_clamped_s;

    // One extra bit keeps the 2**WIDTH case exact: top is detected when
    // cnt+1 reaches MODULUS, bottom when cnt-1 borrows out of the top bit.
    assign cnt_ext_s      = {1'b0, cnt_q};
    assign sum_s          = cnt_ext_s + ONE_W;
    assign diff_s         = cnt_ext_s - ONE_W;
    assign at_top_s       = (sum_s == MOD_W);
    assign at_bot_s       = diff_s[WIDTH];
    assign load_ext_s     = {1'b0, i_load_val};
    assign load_clamped_s = (load_ext_s >= MOD_W) ? LIMIT : i_load_val;

    assign o_tc   = i_en & (((i_dir == CNT_DIR_UP) & at_top_s) |
                            ((i_dir == CNT_DIR_DOWN) & at_bot_s));
    assign o_cnt  = cnt_q;
    assign o_wrap = wrap_q;
    assign o_sat  = sat_q;

    // Next-state: clear beats load beats count; o_sat is a level held until a real move.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        if (i_clr) begin
            cnt_d = {WIDTH{1'b0}};
            sat_d = 1'b0;
        end else if (i_load) begin
            cnt_d = load_clamped_s;
            sat_d = 1'b0;
        end else if (i_en) begin
            case (i_dir)
                CNT_DIR_UP: begin
                    if (!at_top_s) begin
                        cnt_d = sum_s[WIDTH-1:0];
                        sat_d = 1'b0;
                    end else if (SATURATE) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d  = {WIDTH{1'b0}};
                        wrap_d = 1'b1;
                        sat_d  = 1'b0;
                    end
                end
                CNT_DIR_DOWN: begin
                    if (!at_bot_s) begin
                        cnt_d = diff_s[WIDTH-1:0];
                        sat_d = 1'b0;
                    end else if (SATURATE) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d  = LIMIT;
                        wrap_d = 1'b1;
                        sat_d  = 1'b0;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                    sat_d = sat_q;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= {WIDTH{1'b0}};
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

endmodule
